sobel_calc_pipe: RTL and testbench

SOBEL_CALC_PIPE -- requirements
Module: sobel_calc_pipe

---
 rtl/sobel_calc_pipe.sv | 180 ++++++++++++++++++
 tb/tb_sobel_calc_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_calc_pipe.sv
// Three-stage Sobel gradient magnitude with valid/ready flow control.
// Optional SOBEL_THRESH_EN binarises the result against thresh_i.
module sobel_calc_pipe #(
    parameter int DATA_W       = 8,
    parameter int PIPE_REG_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d0_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    input  logic [DATA_W-1:0] d3_i,
    input  logic [DATA_W-1:0] d4_i,
    input  logic [DATA_W-1:0] d5_i,
    input  logic [DATA_W-1:0] d6_i,
    input  logic [DATA_W-1:0] d7_i,
    input  logic [DATA_W-1:0] d8_i,
    input  logic              done_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] thresh_i,
    input  logic              ready_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] grayscale_o,
    output logic              done_o
);
    localparam int PW = DATA_W + 2;
    localparam int SW = DATA_W + 3;

    logic adv;
    logic take;

    assign adv     = ready_i | ~done_o;
    assign ready_o = adv;
    assign take    = done_i & adv;

    // d4 carries no weight in either kernel
    logic unused_centre;
    assign unused_centre = ^d4_i;

    logic [PW-1:0] s1_gxp_q, s1_gxp_d;
    logic [PW-1:0] s1_gxn_q, s1_gxn_d;
    logic [PW-1:0] s1_gyp_q, s1_gyp_d;
    logic [PW-1:0] s1_gyn_q, s1_gyn_d;
    logic          s1_mode_q, s1_mode_d;
    logic          s1_vld_q, s1_vld_d;

    always_comb begin
        s1_gxp_d  = s1_gxp_q;
        s1_gxn_d  = s1_gxn_q;
        s1_gyp_d  = s1_gyp_q;
        s1_gyn_d  = s1_gyn_q;
        s1_mode_d = s1_mode_q;
        s1_vld_d  = s1_vld_q;
        if (adv) begin
            s1_vld_d = done_i;
        end
        if (take) begin
            s1_gxp_d  = PW'(d0_i) + (PW'(d3_i) << 1) + PW'(d6_i);
            s1_gxn_d  = PW'(d2_i) + (PW'(d5_i) << 1) + PW'(d8_i);
            s1_gyp_d  = PW'(d0_i) + (PW'(d1_i) << 1) + PW'(d2_i);
            s1_gyn_d  = PW'(d6_i) + (PW'(d7_i) << 1) + PW'(d8_i);
            s1_mode_d = mode_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_gxp_q  <= '0;
            s1_gxn_q  <= '0;
            s1_gyp_q  <= '0;
            s1_gyn_q  <= '0;
            s1_mode_q <= 1'b0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_gxp_q  <= s1_gxp_d;
            s1_gxn_q  <= s1_gxn_d;
            s1_gyp_q  <= s1_gyp_d;
            s1_gyn_q  <= s1_gyn_d;
            s1_mode_q <= s1_mode_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    logic signed [SW-1:0] gx;
    logic signed [SW-1:0] gy;
    logic [PW-1:0]        s2_agx_q, s2_agx_d;
    logic [PW-1:0]        s2_agy_q, s2_agy_d;
    logic                 s2_mode_q, s2_mode_d;
    logic                 s2_vld_q, s2_vld_d;

    always_comb begin
        gx = $signed({1'b0, s1_gxp_q}) - $signed({1'b0, s1_gxn_q});
        gy = $signed({1'b0, s1_gyp_q}) - $signed({1'b0, s1_gyn_q});
        s2_agx_d  = s2_agx_q;
        s2_agy_d  = s2_agy_q;
        s2_mode_d = s2_mode_q;
        s2_vld_d  = s2_vld_q;
        if (adv) begin
            s2_vld_d = s1_vld_q;
        end
        // data only moves with a real window so bubbles leave it intact
        if (adv && s1_vld_q) begin
            s2_agx_d  = gx[SW-1] ? PW'(-gx) : PW'(gx);
            s2_agy_d  = gy[SW-1] ? PW'(-gy) : PW'(gy);
            s2_mode_d = s1_mode_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_agx_q  <= '0;
            s2_agy_q  <= '0;
            s2_mode_q <= 1'b0;
            s2_vld_q  <= 1'b0;
        end else begin
            s2_agx_q  <= s2_agx_d;
            s2_agy_q  <= s2_agy_d;
            s2_mode_q <= s2_mode_d;
            s2_vld_q  <= s2_vld_d;
        end
    end

    logic [SW-1:0]     l1;
    logic [PW-1:0]     mx;
    logic [SW-1:0]     mag;
    logic [DATA_W-1:0] sat;
    logic [DATA_W-1:0] res;

    always_comb begin
        l1  = SW'(s2_agx_q) + SW'(s2_agy_q);
        mx  = (s2_agx_q >= s2_agy_q) ? s2_agx_q : s2_agy_q;
        mag = s2_mode_q ? SW'(mx) : l1;
        sat = (mag > SW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}}
                                          : mag[DATA_W-1:0];
`ifdef SOBEL_THRESH_EN
        res = (sat > thresh_i) ? {DATA_W{1'b1}} : '0;
`else
        res = sat;
`endif
    end

`ifndef SOBEL_THRESH_EN
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
`endif

    generate
        if (PIPE_REG_OUT != 0) begin : g_reg
            logic [DATA_W-1:0] out_q, out_d;
            logic              vo_q, vo_d;

            always_comb begin
                out_d = out_q;
                vo_d  = vo_q;
                if (adv) begin
                    vo_d = s2_vld_q;
                end
                if (adv && s2_vld_q) begin
                    out_d = res;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                    vo_q  <= 1'b0;
                end else begin
                    out_q <= out_d;
                    vo_q  <= vo_d;
                end
            end

            assign grayscale_o = out_q;
            assign done_o      = vo_q;
        end else begin : g_comb
            assign grayscale_o = res;
            assign done_o      = s2_vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_sobel_calc_pipe.sv
// Bench for sobel_calc_pipe: vector table, stall/reset sequences, random stream.
module tb_sobel_calc_pipe;
    localparam int W = 8;

    typedef logic [8:0][7:0] win_t;
    typedef struct packed {
        win_t       px;
        logic       m;
        logic [7:0] thr;
        logic [9:0] raw;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d [9];
    logic         done_i, mode_i, ready_i;
    logic [W-1:0] thresh_i;
    logic         ready_o, done_o;
    logic [W-1:0] grayscale_o;

    int n_cmp = 0;
    int n_bad = 0;

    sobel_calc_pipe #(.DATA_W(W), .PIPE_REG_OUT(1)) dut (
        .clk(clk), .rst(rst),
        .d0_i(d[0]), .d1_i(d[1]), .d2_i(d[2]),
        .d3_i(d[3]), .d4_i(d[4]), .d5_i(d[5]),
        .d6_i(d[6]), .d7_i(d[7]), .d8_i(d[8]),
        .done_i(done_i), .mode_i(mode_i), .thresh_i(thresh_i),
        .ready_i(ready_i), .ready_o(ready_o),
        .grayscale_o(grayscale_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic win_t mkw(int a0, int a1, int a2, int a3, int a4,
                                 int a5, int a6, int a7, int a8);
        win_t p;
        p[0] = 8'(a0); p[1] = 8'(a1); p[2] = 8'(a2);
        p[3] = 8'(a3); p[4] = 8'(a4); p[5] = 8'(a5);
        p[6] = 8'(a6); p[7] = 8'(a7); p[8] = 8'(a8);
        return p;
    endfunction

    function automatic int fin(int raw, int thr);
        int r;
        r = (raw > 255) ? 255 : raw;
`ifdef SOBEL_THRESH_EN
        r = (r > thr) ? 255 : 0;
`endif
        return r;
    endfunction

    function automatic int ref_out(win_t p, bit m, int thr);
        int gx, gy, ax, ay;
        gx = (int'(p[0]) + 2 * int'(p[3]) + int'(p[6]))
           - (int'(p[2]) + 2 * int'(p[5]) + int'(p[8]));
        gy = (int'(p[0]) + 2 * int'(p[1]) + int'(p[2]))
           - (int'(p[6]) + 2 * int'(p[7]) + int'(p[8]));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        return fin(m ? ((ax > ay) ? ax : ay) : ax + ay, thr);
    endfunction

    function automatic logic [7:0] rpx();
        case ($urandom % 4)
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom % 256);
        endcase
    endfunction

    task automatic drive(win_t p, bit m);
        for (int i = 0; i < 9; i++) d[i] = p[i];
        mode_i = m;
    endtask

    task automatic apply_vec(string nm, win_t p, bit m, int thr, int exp);
        int lat;
        @(negedge clk);
        drive(p, m);
        thresh_i = 8'(thr);
        done_i   = 1'b1;
        ready_i  = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        lat    = 1;
        while (!done_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, 3);
        chk(nm, grayscale_o, exp);
    endtask

    task automatic run_stream(string nm, bit directed, int ncyc);
        int   q[$];
        win_t cur;
        bit   cm = 1'b0;
        bit   pend = 1'b0;
        bit   prev_stall = 1'b0;
        int   sent = 0, got = 0, stall_left = 3, prev_g = 0, exp, thr;
        thr = $urandom % 256;
        for (int c = 0; c < ncyc + 12; c++) begin
            @(negedge clk);
            if (!pend) begin
                for (int i = 0; i < 9; i++) cur[i] = rpx();
                cm = 1'($urandom % 2);
            end
            drive(cur, cm);
            thresh_i = 8'(thr);
            if (c >= ncyc)     done_i = 1'b0;
            else if (directed) done_i = (sent < 4);
            else               done_i = ($urandom % 4) != 0;
            if (c >= ncyc) begin
                ready_i = 1'b1;
            end else if (directed) begin
                if (done_o && stall_left > 0) begin
                    ready_i = 1'b0;
                    stall_left--;
                end else begin
                    ready_i = 1'b1;
                end
            end else begin
                ready_i = ($urandom % 3) != 0;
            end
            #1;
            if (done_o) begin
                if (prev_stall) chk({nm, "_hold"}, grayscale_o, prev_g);
                if (!ready_i) begin
                    chk({nm, "_ready_o"}, ready_o, 0);
                end else if (q.size() == 0) begin
                    chk({nm, "_extra"}, done_o, 0);
                end else begin
                    exp = q.pop_front();
                    chk({nm, "_out"}, grayscale_o, exp);
                    got++;
                end
            end
            prev_stall = done_o && !ready_i;
            prev_g     = grayscale_o;
            if (done_i && ready_o) begin
                q.push_back(ref_out(cur, cm, thr));
                sent++;
                pend = 1'b0;
            end else begin
                pend = done_i;
            end
        end
        chk({nm, "_drain"}, q.size(), 0);
        chk({nm, "_count"}, got, sent);
        if (directed) chk({nm, "_sent"}, sent, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    initial begin
        vec_t tv[$];
        win_t w19;
        w19 = mkw(1, 2, 3, 4, 5, 6, 7, 8, 9);

        tv.push_back('{w19, 1'b0, 8'd0, 10'd32});
        tv.push_back('{w19, 1'b1, 8'd0, 10'd24});
        tv.push_back('{mkw(100, 100, 100, 100, 100, 100, 100, 100, 100), 1'b0, 8'd0, 10'd0});
        tv.push_back('{mkw(100, 100, 100, 100, 100, 100, 100, 100, 100), 1'b1, 8'd0, 10'd0});
        tv.push_back('{mkw(255, 0, 0, 255, 0, 0, 255, 0, 0), 1'b0, 8'd0, 10'd1020});
        tv.push_back('{mkw(255, 0, 0, 255, 0, 0, 255, 0, 0), 1'b1, 8'd0, 10'd1020});
        tv.push_back('{mkw(0, 0, 255, 0, 0, 255, 0, 0, 255), 1'b0, 8'd0, 10'd1020});
        tv.push_back('{mkw(0, 0, 0, 0, 255, 0, 0, 0, 0), 1'b0, 8'd0, 10'd0});
        tv.push_back('{mkw(0, 10, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'd0, 10'd20});
        tv.push_back('{mkw(10, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 10'd20});
        tv.push_back('{mkw(10, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'd0, 10'd10});
        tv.push_back('{mkw(0, 0, 0, 0, 0, 0, 0, 0, 50), 1'b0, 8'd0, 10'd100});
        tv.push_back('{mkw(0, 0, 0, 0, 0, 0, 0, 0, 50), 1'b1, 8'd0, 10'd50});
        tv.push_back('{mkw(40, 0, 0, 40, 0, 0, 40, 0, 0), 1'b0, 8'd0, 10'd160});
        tv.push_back('{mkw(200, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 10'd400});
        tv.push_back('{mkw(200, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'd0, 10'd200});
        tv.push_back('{mkw(0, 0, 0, 127, 0, 0, 0, 0, 0), 1'b0, 8'd0, 10'd254});
        tv.push_back('{mkw(0, 0, 0, 128, 0, 0, 0, 0, 0), 1'b0, 8'd0, 10'd256});
        tv.push_back('{w19, 1'b0, 8'd31, 10'd32});
        tv.push_back('{w19, 1'b0, 8'd32, 10'd32});

        rst      = 1'b1;
        done_i   = 1'b0;
        ready_i  = 1'b1;
        thresh_i = '0;
        drive(w19, 1'b0);
        #12;
        chk("rst_ready_o", ready_o, 1);
        chk("rst_done_o", done_o, 0);
        chk("rst_gray", grayscale_o, 0);
        done_i = 1'b1;
        repeat (3) @(negedge clk);
        done_i = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_discard", done_o, 0);
        end

        foreach (tv[i]) begin
            apply_vec($sformatf("vec%0d", i), tv[i].px, tv[i].m,
                      int'(tv[i].thr), fin(int'(tv[i].raw), int'(tv[i].thr)));
        end

        run_stream("stall", 1'b1, 20);

        apply_vec("pre_rst", w19, 1'b0, 0, fin(32, 0));
        @(negedge clk);
        drive(w19, 1'b0);
        done_i  = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        drive(mkw(255, 0, 0, 255, 0, 0, 255, 0, 0), 1'b1);
        @(negedge clk);
        done_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_done_o", done_o, 0);
        chk("async_gray", grayscale_o, 0);
        chk("async_ready_o", ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", done_o, 0);
        end
        apply_vec("post_rst", w19, 1'b1, 0, fin(24, 0));

        run_stream("rand", 1'b0, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
